// File: rtl/synth_meter_pkg.sv
// Shared types and sizing for the zero-crossing frequency meter.
package synth_meter_pkg;

   typedef enum logic {SEEK = 1'b0, MEASURE = 1'b1} fsm_state_t;
   typedef enum logic {NEG = 1'b0, POS = 1'b1} sign_state_t;

   localparam int DIV_ITER = 32;
   localparam int NUM_W    = 37;

endpackage

// File: rtl/serial_divider.sv
// Restoring divider producing one quotient bit per clock.
// busy covers the 32 iteration cycles; done and quotient are valid during the last one.
module serial_divider
   import synth_meter_pkg::*;
#(
   parameter int CNT_W = 24
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             start,
   input  logic [NUM_W-1:0] numerator,
   input  logic [CNT_W-1:0] denominator,
   output logic             busy,
   output logic             done,
   output logic [31:0]      quotient
);

   localparam int HI_W  = NUM_W - DIV_ITER;
   localparam int REM_W = ((CNT_W > HI_W) ? CNT_W : HI_W) + 1;
   localparam logic [4:0] LAST = 5'(DIV_ITER - 1);

   logic             busy_q, busy_d;
   logic [4:0]       iter_q, iter_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic [31:0]      num_q, num_d;
   logic [31:0]      quo_q, quo_d;
   logic [CNT_W-1:0] den_q, den_d;
   logic [REM_W-1:0] trial;
   logic             fits;

   // Upper numerator bits seed the remainder; they are below the divisor, so the
   // quotient never needs more than 32 bits.
   always_comb begin
      trial  = {rem_q[REM_W-2:0], num_q[31]};
      fits   = (trial >= REM_W'(den_q));
      busy_d = busy_q;
      iter_d = iter_q;
      rem_d  = rem_q;
      num_d  = num_q;
      quo_d  = quo_q;
      den_d  = den_q;
      if (start && !busy_q) begin
         busy_d = 1'b1;
         iter_d = '0;
         rem_d  = REM_W'(numerator[NUM_W-1:DIV_ITER]);
         num_d  = numerator[DIV_ITER-1:0];
         quo_d  = '0;
         den_d  = denominator;
      end else if (busy_q) begin
         rem_d  = fits ? (trial - REM_W'(den_q)) : trial;
         num_d  = {num_q[30:0], 1'b0};
         quo_d  = {quo_q[30:0], fits};
         iter_d = iter_q + 5'd1;
         if (iter_q == LAST) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy_q <= 1'b0;
         iter_q <= '0;
         rem_q  <= '0;
         num_q  <= '0;
         quo_q  <= '0;
         den_q  <= '0;
      end else begin
         busy_q <= busy_d;
         iter_q <= iter_d;
         rem_q  <= rem_d;
         num_q  <= num_d;
         quo_q  <= quo_d;
         den_q  <= den_d;
      end
   end

   assign busy     = busy_q;
   assign done     = busy_q && (iter_q == LAST);
   assign quotient = {quo_q[30:0], fits};

endmodule

// File: rtl/zero_cross_freq_meter.sv
// Measures the fundamental of a signed sample stream from hysteresis zero crossings
// and converts the window length into an equivalent 32-bit phase increment.
module zero_cross_freq_meter
   import synth_meter_pkg::*;
#(
   parameter logic [31:0] HYST        = 32'd256,
   parameter int          NUM_PERIODS = 4,
   parameter int          CNT_W       = 24
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        step_in,
   input  logic [31:0] sample_in,
   output logic [31:0] phase_incr_out,
   output logic        valid_out,
   output logic        locked_out,
   output logic        busy_out
);

   localparam logic [NUM_W-1:0] NUMERATOR  = NUM_W'(NUM_PERIODS) << DIV_ITER;
   localparam logic [4:0]       PER_TARGET = 5'(NUM_PERIODS);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   sign_state_t      sign_q, sign_d;
   fsm_state_t       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d, cnt_inc;
   logic [4:0]       per_q, per_d, per_inc;
   logic [CNT_W-1:0] den_q, den_d;
   logic             start_q, start_d;
   logic             stale_q, stale_d;
   logic [31:0]      phase_q, phase_d;
   logic             valid_q, valid_d;
   logic             locked_q, locked_d;
   logic             timeout;

   logic signed [32:0] sample_s, hyst_pos, hyst_neg;
   logic               above, below, rise;
   logic               div_busy, div_done;
   logic [31:0]        div_quot;

   assign sample_s = $signed({sample_in[31], sample_in});
   assign hyst_pos = $signed({1'b0, HYST});
   assign hyst_neg = -hyst_pos;
   assign above    = (sample_s >= hyst_pos);
   assign below    = (sample_s <= hyst_neg);
   assign rise     = step_in && (sign_q == NEG) && above;

   always_comb begin
      sign_d   = sign_q;
      state_d  = state_q;
      count_d  = count_q;
      per_d    = per_q;
      den_d    = den_q;
      start_d  = 1'b0;
      stale_d  = stale_q;
      phase_d  = phase_q;
      valid_d  = 1'b0;
      locked_d = locked_q;
      timeout  = 1'b0;
      cnt_inc  = count_q + 1'b1;
      per_inc  = per_q + {4'd0, rise};

      if (step_in) begin
         if (above)      sign_d = POS;
         else if (below) sign_d = NEG;
      end

      // The crossing that closes a window also opens the next one.
      case (state_q)
         SEEK: begin
            if (rise) begin
               count_d = '0;
               per_d   = '0;
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (step_in) begin
               if (per_inc == PER_TARGET) begin
                  count_d = '0;
                  per_d   = '0;
                  if (!div_busy && !start_q) begin
                     start_d = 1'b1;
                     den_d   = cnt_inc;
                  end
               end else if (cnt_inc == CNT_MAX) begin
                  timeout = 1'b1;
                  count_d = '0;
                  per_d   = '0;
                  state_d = SEEK;
               end else begin
                  count_d = cnt_inc;
                  per_d   = per_inc;
               end
            end
         end
         default: state_d = SEEK;
      endcase

      // A timeout after a division was launched keeps that result from relocking.
      if (start_q) stale_d = 1'b0;
      if (timeout) stale_d = 1'b1;

      if (div_done) begin
         phase_d = div_quot;
         valid_d = 1'b1;
         if (!stale_q) locked_d = 1'b1;
      end
      if (timeout) locked_d = 1'b0;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         sign_q   <= NEG;
         state_q  <= SEEK;
         count_q  <= '0;
         per_q    <= '0;
         den_q    <= '0;
         start_q  <= 1'b0;
         stale_q  <= 1'b0;
         phase_q  <= '0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         sign_q   <= sign_d;
         state_q  <= state_d;
         count_q  <= count_d;
         per_q    <= per_d;
         den_q    <= den_d;
         start_q  <= start_d;
         stale_q  <= stale_d;
         phase_q  <= phase_d;
         valid_q  <= valid_d;
         locked_q <= locked_d;
      end
   end

   serial_divider #(
      .CNT_W(CNT_W)
   ) u_div (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .start      (start_q),
      .numerator  (NUMERATOR),
      .denominator(den_q),
      .busy       (div_busy),
      .done       (div_done),
      .quotient   (div_quot)
   );

   assign phase_incr_out = phase_q;
   assign valid_out      = valid_q;
   assign locked_out     = locked_q;
   assign busy_out       = div_busy;

endmodule

// File: tb/tb_zero_cross_freq_meter.sv
// Bench for zero_cross_freq_meter: vector table, latency/reset/timeout sequences, random waveforms.
module tb_zero_cross_freq_meter;

   localparam int NP = 4;
   localparam int CW = 10;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        step_in;
   logic [31:0] sample_in;
   logic [31:0] phase_incr_out;
   logic        valid_out;
   logic        locked_out;
   logic        busy_out;

   always #5 clk_in = ~clk_in;

   zero_cross_freq_meter #(
      .HYST       (32'd256),
      .NUM_PERIODS(NP),
      .CNT_W      (CW)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .step_in       (step_in),
      .sample_in     (sample_in),
      .phase_incr_out(phase_incr_out),
      .valid_out     (valid_out),
      .locked_out    (locked_out),
      .busy_out      (busy_out)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [31:0] vq[$];
   int          vt[$];
   logic        lq[$];
   int          bq[$];
   int          busy_run = 0;

   always @(posedge clk_in) cyc <= cyc + 1;

   always @(negedge clk_in) begin
      if (valid_out) begin
         vq.push_back(phase_incr_out);
         vt.push_back(cyc);
         lq.push_back(locked_out);
      end
      if (!rst_in) busy_run = 0;
      else if (busy_out) busy_run++;
      else if (busy_run != 0) begin
         bq.push_back(busy_run);
         busy_run = 0;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input logic s, input logic [31:0] x);
      step_in   = s;
      sample_in = x;
      @(posedge clk_in);
      #1;
   endtask

   task automatic put(input logic [31:0] x, input int gap);
      tick(1'b1, x);
      for (int i = 1; i < gap; i++) tick(1'b0, x);
   endtask

   task automatic square(input logic [31:0] hi, input logic [31:0] lo, input int half,
                         input int gap, input int periods);
      for (int p = 0; p < periods; p++) begin
         for (int i = 0; i < half; i++) put(hi, gap);
         for (int i = 0; i < half; i++) put(lo, gap);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 32'd0);
   endtask

   task automatic do_reset();
      step_in   = 1'b0;
      sample_in = 32'd0;
      rst_in    = 1'b0;
      repeat (3) @(posedge clk_in);
      #1 rst_in = 1'b1;
   endtask

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          half;
      int          gap;
      int          periods;
      int          pulses;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[4];

   initial begin
      int          base, bbase, t_mark, per, gap, h;
      logic [31:0] x, expv;
      longint unsigned num;

      tbl[0] = '{32'd1000,     32'hFFFFFC18, 50, 4, 14, 3, 32'h028F5C28};
      tbl[1] = '{32'h7FFFFFFF, 32'h80000000, 25, 1, 14, 3, 32'h051EB851};
      tbl[2] = '{32'd1000,     32'hFFFFFC18,  1, 1, 60, 3, 32'h80000000};
      tbl[3] = '{32'd256,      32'hFFFFFF00, 20, 2, 14, 3, 32'h06666666};

      rst_in    = 1'b0;
      step_in   = 1'b0;
      sample_in = 32'd0;
      #2;
      check("reset phase", phase_incr_out, 0);
      check("reset valid", valid_out, 0);
      check("reset locked", locked_out, 0);
      check("reset busy", busy_out, 0);

      // Table of steady square waves
      for (int r = 0; r < 4; r++) begin
         do_reset();
         base  = vq.size();
         bbase = bq.size();
         square(tbl[r].hi, tbl[r].lo, tbl[r].half, tbl[r].gap, tbl[r].periods);
         idle(40);
         check($sformatf("row%0d pulse count", r), vq.size() - base, tbl[r].pulses);
         for (int k = base; k < vq.size(); k++) begin
            check($sformatf("row%0d value #%0d", r, k - base), vq[k], tbl[r].exp);
            check($sformatf("row%0d locked #%0d", r, k - base), lq[k], 1);
            if (k > base)
               check($sformatf("row%0d spacing>=33", r), (vt[k] - vt[k-1]) >= 33, 1);
         end
         for (int k = bbase; k < bq.size(); k++)
            check($sformatf("row%0d busy length", r), bq[k], 32);
         check($sformatf("row%0d locked held", r), locked_out, 1);
      end

      // Exact latency of the first measurement
      do_reset();
      square(32'd1000, 32'hFFFFFC18, 50, 1, 4);
      tick(1'b1, 32'd1000);
      t_mark = cyc;
      step_in = 1'b0;
      for (int k = 0; k <= 35; k++) begin
         @(negedge clk_in);
         check($sformatf("lat busy T+%0d", k), busy_out, (k >= 1 && k <= 32));
         check($sformatf("lat valid T+%0d", k), valid_out, (k == 33));
         if (k == 32) check("lat phase before write", phase_incr_out, 0);
         if (k == 33) check("lat phase written", phase_incr_out, 32'h028F5C28);
      end
      check("lat edge bookkeeping", cyc - t_mark, 35);

      // Reset in the middle of a division
      do_reset();
      square(32'd1000, 32'hFFFFFC18, 50, 1, 8);
      tick(1'b1, 32'd1000);
      for (int i = 0; i < 10; i++) tick(1'b0, 32'd1000);
      check("mid busy before reset", busy_out, 1);
      check("mid locked before reset", locked_out, 1);
      rst_in = 1'b0;
      #1;
      check("mid async phase", phase_incr_out, 0);
      check("mid async valid", valid_out, 0);
      check("mid async locked", locked_out, 0);
      check("mid async busy", busy_out, 0);
      repeat (2) @(posedge clk_in);
      #1 rst_in = 1'b1;
      base = vq.size();
      idle(40);
      check("mid no late valid", vq.size() - base, 0);
      square(32'd1000, 32'hFFFFFC18, 50, 1, 14);
      idle(40);
      check("mid relock count", vq.size() - base, 3);
      for (int k = base; k < vq.size(); k++)
         check("mid relock value", vq[k], 32'h028F5C28);
      check("mid relock locked", locked_out, 1);

      // Timeout while wobbling inside the hysteresis band
      do_reset();
      base = vq.size();
      square(32'd1000, 32'hFFFFFC18, 50, 1, 8);
      tick(1'b1, 32'd1000);
      for (int i = 1; i <= 1022; i++) tick(1'b1, (i % 2) ? 32'd200 : 32'hFFFFFF38);
      check("tmo locked before limit", locked_out, 1);
      check("tmo pulses before limit", vq.size() - base, 2);
      tick(1'b1, 32'd200);
      check("tmo locked cleared", locked_out, 0);
      check("tmo phase held", phase_incr_out, 32'h028F5C28);
      check("tmo busy idle", busy_out, 0);
      base = vq.size();
      for (int i = 0; i < 50; i++) put(32'hFFFFFC18, 1);
      square(32'd1000, 32'hFFFFFC18, 50, 1, 14);
      idle(40);
      check("tmo relock count", vq.size() - base, 3);
      for (int k = base; k < vq.size(); k++)
         check("tmo relock value", vq[k], 32'h028F5C28);
      check("tmo relock locked", locked_out, 1);

      // Random waveforms against the period-based model
      for (int r = 0; r < 6; r++) begin
         per = int'($urandom_range(9, 120));
         gap = int'($urandom_range(1, 2));
         h   = int'($urandom_range(1, per - 1));
         do_reset();
         base = vq.size();
         for (int p = 0; p < 14; p++) begin
            for (int i = 0; i < per; i++) begin
               if (i != 0 && i != h && $urandom_range(0, 3) == 0)
                  x = 32'($urandom_range(0, 510)) - 32'd255;
               else if (i < h)
                  x = 32'd256 + ($urandom % 32'h7FFFFF00);
               else
                  x = 32'd0 - (32'd256 + ($urandom % 32'h7FFFFF01));
               put(x, gap);
            end
         end
         idle(40);
         num  = longint'(NP) << 32;
         expv = 32'(num / longint'(NP * per));
         check($sformatf("rand%0d P=%0d count", r, per), vq.size() - base, 3);
         for (int k = base; k < vq.size(); k++)
            check($sformatf("rand%0d P=%0d value", r, per), vq[k], expv);
         check($sformatf("rand%0d locked", r), locked_out, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
